// File: rtl/dcache_wb.sv
// Two-way set-associative write-back, write-allocate data cache with one-word lines.
// Misses stall the CPU while a WRITEBACK/FILL state machine talks to backing memory.
module dcache_wb #(
  parameter int DATA_WIDTH        = 32,
  parameter int SET_ADDRESS_WIDTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic                  WE2,
  input  logic                  WE3,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  hit,
  output logic                  Stall,
  output logic                  MemReq,
  output logic                  MemWE,
  output logic [DATA_WIDTH-1:0] MemA,
  output logic [DATA_WIDTH-1:0] MemWD,
  input  logic [DATA_WIDTH-1:0] MemRD,
  input  logic                  MemReady
);

  localparam int TAG_WIDTH = DATA_WIDTH - SET_ADDRESS_WIDTH - 2;
  localparam int SETS      = 1 << SET_ADDRESS_WIDTH;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t state_q, state_d;
  logic   victim_q, victim_d;

  logic [1:0]            v_q   [SETS];
  logic [1:0]            d_q   [SETS];
  logic [SETS-1:0]       lru_q;
  logic [TAG_WIDTH-1:0]  tag_q [2][SETS];
  logic [DATA_WIDTH-1:0] data_q[2][SETS];

  logic [SET_ADDRESS_WIDTH-1:0] set_idx;
  logic [TAG_WIDTH-1:0]         tag_in;
  logic [1:0]                   way_hit;
  logic                         hit_way;
  logic                         req;
  logic                         wr_hit;
  logic                         fill_en;
  logic                         unused_addr_lsb;

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [3:0]            be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign set_idx         = A[SET_ADDRESS_WIDTH+1:2];
  assign tag_in          = A[DATA_WIDTH-1:SET_ADDRESS_WIDTH+2];
  assign unused_addr_lsb = ^A[1:0];
  assign req             = MemRead | MemWrite;

  assign way_hit[0] = v_q[set_idx][0] && (tag_q[0][set_idx] == tag_in);
  assign way_hit[1] = v_q[set_idx][1] && (tag_q[1][set_idx] == tag_in);
  assign hit_way    = way_hit[1];

  assign hit    = (state_q == IDLE) && req && (|way_hit);
  assign wr_hit = hit && MemWrite;
  assign RD     = (hit && MemRead) ? data_q[hit_way][set_idx] : '0;

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    Stall    = 1'b0;
    MemReq   = 1'b0;
    MemWE    = 1'b0;
    MemA     = '0;
    MemWD    = '0;
    fill_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !(|way_hit)) begin
          Stall = 1'b1;
          // Fill empty ways before evicting anything
          if (!v_q[set_idx][0])      victim_d = 1'b0;
          else if (!v_q[set_idx][1]) victim_d = 1'b1;
          else                       victim_d = lru_q[set_idx];
          state_d = (v_q[set_idx][victim_d] && d_q[set_idx][victim_d]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        Stall  = 1'b1;
        MemReq = 1'b1;
        MemWE  = 1'b1;
        MemA   = {tag_q[victim_q][set_idx], set_idx, 2'b00};
        MemWD  = data_q[victim_q][set_idx];
        if (MemReady) state_d = FILL;
      end
      FILL: begin
        Stall  = 1'b1;
        MemReq = 1'b1;
        MemA   = {tag_in, set_idx, 2'b00};
        if (MemReady) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      lru_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        v_q[s] <= '0;
        d_q[s] <= '0;
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (hit) lru_q[set_idx] <= ~hit_way;
      if (wr_hit) d_q[set_idx][hit_way] <= 1'b1;
      if (fill_en) begin
        v_q[set_idx][victim_q] <= 1'b1;
        d_q[set_idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tag/data arrays carry no reset; validity alone decides whether they are used
  always_ff @(posedge CLK) begin
    if (wr_hit) begin
      data_q[hit_way][set_idx] <= byte_merge(data_q[hit_way][set_idx], WD, {WE3, WE2, WE1, WE0});
    end
    if (fill_en) begin
      tag_q[victim_q][set_idx]  <= tag_in;
      data_q[victim_q][set_idx] <= MemRD;
    end
  end

endmodule
